// File: rtl/interrupt_pkg.sv
// Shared register map, FSM state type and priority helper for the interrupt controller.
package interrupt_pkg;

    localparam int unsigned NumIrqMax = 8;

    localparam logic [2:0] RegEnable  = 3'd0;
    localparam logic [2:0] RegPending = 3'd1;
    localparam logic [2:0] RegEdge    = 3'd2;
    localparam logic [2:0] RegStatus  = 3'd3;
    localparam logic [2:0] RegEoi     = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StRequest,
        StInService
    } irq_state_e;

    // Fixed priority: the lowest set index wins.
    function automatic logic [2:0] lowest_set(input logic [NumIrqMax-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NumIrqMax - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous interrupt line plus a rising-edge pulse.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritising interrupt controller: sync, pending latch, mask, fixed-priority request to the
// CPU with ack/EOI handshake, and a small register port.
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq_in,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_write,
    input  logic        reg_read,
    output logic [31:0] reg_rdata,
    output logic [7:0]  interrupt_req,
    input  logic        interrupt_ack,
    output logic [2:0]  irq_vector,
    output logic        irq_active
);

    logic [NUM_IRQ-1:0] sync, rise;
    logic [NUM_IRQ-1:0] enable_q, enable_d, edge_mode_q, edge_mode_d, pending_q, pending_d;
    logic [NUM_IRQ-1:0] w1c, ack_clr;
    logic [7:0]         eligible, vec_onehot, req_q, req_d;
    logic [2:0]         vector_q, vector_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               eoi;
    irq_state_e         state_q, state_d;

    logic unused_wdata;
    assign unused_wdata = ^reg_wdata[31:8];

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .async_i(irq_in[g]),
            .sync_o (sync[g]),
            .rise_o (rise[g])
        );
    end

    assign eligible   = 8'(pending_q & enable_q);
    assign vec_onehot = 8'd1 << vector_q;
    assign eoi        = reg_write && (reg_addr == RegEoi);
    assign w1c        = (reg_write && reg_addr == RegPending) ? reg_wdata[NUM_IRQ-1:0] : '0;
    assign ack_clr    = (state_q == StRequest && interrupt_ack) ?
                        (vec_onehot[NUM_IRQ-1:0] & edge_mode_q) : '0;

    always_comb begin
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        if (reg_write && reg_addr == RegEnable) enable_d = reg_wdata[NUM_IRQ-1:0];
        if (reg_write && reg_addr == RegEdge) edge_mode_d = reg_wdata[NUM_IRQ-1:0];
        // New edges are ORed in last so they survive a same-cycle W1C or ack clear.
        pending_d = (edge_mode_q & ((pending_q & ~w1c & ~ack_clr) | rise))
                  | (~edge_mode_q & sync);
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        vector_d = vector_q;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d  = StRequest;
                    vector_d = lowest_set(eligible);
                    req_d    = 8'd1 << vector_d;
                end
            end
            StRequest: begin
                if (interrupt_ack) begin
                    state_d = StInService;
                    req_d   = '0;
                end else if (!eligible[vector_q]) begin
                    state_d = StIdle;
                    req_d   = '0;
                end
            end
            StInService: begin
                if (eoi) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = '0;
            end
        endcase
    end

    // Read data is taken from current register values, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = rdata_q;
        if (reg_read) begin
            case (reg_addr)
                RegEnable:  rdata_d = 32'(enable_q);
                RegPending: rdata_d = 32'(pending_q);
                RegEdge:    rdata_d = 32'(edge_mode_q);
                RegStatus:  rdata_d = {24'b0, irq_active, 4'b0, vector_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q    <= '0;
            edge_mode_q <= '0;
            pending_q   <= '0;
            state_q     <= StIdle;
            req_q       <= '0;
            vector_q    <= '0;
            rdata_q     <= '0;
        end else begin
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            req_q       <= req_d;
            vector_q    <= vector_d;
            rdata_q     <= rdata_d;
        end
    end

    assign interrupt_req = req_q;
    assign irq_vector    = vector_q;
    assign irq_active    = (state_q != StIdle);
    assign reg_rdata     = rdata_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed table-driven bench for interrupt_controller with hand-written reset sequences.
module tb_interrupt_controller;

    localparam logic [1:0] N = 2'd0, W = 2'd1, R = 2'd2, WR = 2'd3;

    typedef struct {
        logic [7:0]  irq;
        logic [1:0]  op;
        logic [2:0]  addr;
        logic [7:0]  wdata;
        logic        ack;
        logic [7:0]  exp_req;
        logic [2:0]  exp_vec;
        logic        exp_act;
        logic [31:0] exp_rd;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_write, reg_read;
    logic [31:0] reg_rdata;
    logic [7:0]  interrupt_req;
    logic        interrupt_ack;
    logic [2:0]  irq_vector;
    logic        irq_active;

    step_t tbl[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    interrupt_controller #(
        .NUM_IRQ    (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_write    (reg_write),
        .reg_read     (reg_read),
        .reg_rdata    (reg_rdata),
        .interrupt_req(interrupt_req),
        .interrupt_ack(interrupt_ack),
        .irq_vector   (irq_vector),
        .irq_active   (irq_active)
    );

    task automatic add(input logic [7:0] irq, input logic [1:0] op, input logic [2:0] addr,
                       input logic [7:0] wdata, input logic ack, input logic [7:0] req,
                       input logic [2:0] vec, input logic act, input logic [31:0] rd);
        step_t s;
        s.irq = irq; s.op = op; s.addr = addr; s.wdata = wdata; s.ack = ack;
        s.exp_req = req; s.exp_vec = vec; s.exp_act = act; s.exp_rd = rd;
        tbl.push_back(s);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; reg_addr = '0; reg_wdata = '0;
        reg_write = 1'b0; reg_read = 1'b0; interrupt_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {reg_rdata, interrupt_req, 5'(irq_vector), 8'(irq_active)}, 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // irq  op  addr wdata ack  req    vec act rdata
        // 1: single edge on line 3
        add(8'h00, W, 3'd0, 8'hFF, 0, 8'h00, 0, 0, 0);
        add(8'h00, W, 3'd2, 8'hFF, 0, 8'h00, 0, 0, 0);
        add(8'h08, N, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(8'h00, R, 3'd1, 8'h00, 0, 8'h08, 3, 1, 32'h08);
        add(8'h00, N, 3'd0, 8'h00, 1, 8'h00, 3, 1, 0);
        add(8'h00, R, 3'd1, 8'h00, 0, 8'h00, 3, 1, 32'h00);
        add(8'h00, R, 3'd3, 8'h00, 0, 8'h00, 3, 1, 32'h83);
        add(8'h00, W, 3'd4, 8'h00, 0, 8'h00, 3, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 3, 0, 0);
        // 2: simultaneous lines 5 and 2
        add(8'h24, N, 3'd0, 8'h00, 0, 8'h00, 3, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 3, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 3, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h04, 2, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 1, 8'h00, 2, 1, 0);
        add(8'h00, W, 3'd4, 8'h00, 0, 8'h00, 2, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h20, 5, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 1, 8'h00, 5, 1, 0);
        add(8'h00, W, 3'd4, 8'h00, 0, 8'h00, 5, 0, 0);
        // 3: no pre-emption of line 4 by line 1
        add(8'h10, N, 3'd0, 8'h00, 0, 8'h00, 5, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 5, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 5, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h10, 4, 1, 0);
        add(8'h02, N, 3'd0, 8'h00, 0, 8'h10, 4, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h10, 4, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h10, 4, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h10, 4, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 1, 8'h00, 4, 1, 0);
        add(8'h00, W, 3'd4, 8'h00, 0, 8'h00, 4, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h02, 1, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 1, 8'h00, 1, 1, 0);
        add(8'h00, W, 3'd4, 8'h00, 0, 8'h00, 1, 0, 0);
        // 4: level mode on line 0
        add(8'h00, W, 3'd2, 8'hFE, 0, 8'h00, 1, 0, 0);
        add(8'h01, N, 3'd0, 8'h00, 0, 8'h00, 1, 0, 0);
        add(8'h01, N, 3'd0, 8'h00, 0, 8'h00, 1, 0, 0);
        add(8'h01, N, 3'd0, 8'h00, 0, 8'h00, 1, 0, 0);
        add(8'h01, N, 3'd0, 8'h00, 0, 8'h01, 0, 1, 0);
        add(8'h01, N, 3'd0, 8'h00, 1, 8'h00, 0, 1, 0);
        add(8'h01, W, 3'd4, 8'h00, 0, 8'h00, 0, 0, 0);
        add(8'h01, N, 3'd0, 8'h00, 0, 8'h01, 0, 1, 0);
        add(8'h01, N, 3'd0, 8'h00, 1, 8'h00, 0, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 0, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 0, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 0, 1, 0);
        add(8'h00, W, 3'd4, 8'h00, 0, 8'h00, 0, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        // 5: mask before ack, W1C versus new edge, read-during-write
        add(8'h40, N, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h40, 6, 1, 0);
        add(8'h00, W, 3'd0, 8'h00, 0, 8'h40, 6, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 6, 0, 0);
        add(8'h00, R, 3'd1, 8'h00, 0, 8'h00, 6, 0, 32'h40);
        add(8'h40, N, 3'd0, 8'h00, 0, 8'h00, 6, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 6, 0, 0);
        add(8'h00, W, 3'd1, 8'h40, 0, 8'h00, 6, 0, 0);
        add(8'h00, R, 3'd1, 8'h00, 0, 8'h00, 6, 0, 32'h40);
        add(8'h00, W, 3'd1, 8'h40, 0, 8'h00, 6, 0, 0);
        add(8'h00, R, 3'd1, 8'h00, 0, 8'h00, 6, 0, 32'h00);
        add(8'h00, WR, 3'd0, 8'h0F, 0, 8'h00, 6, 0, 32'h00);
        add(8'h00, R, 3'd0, 8'h00, 0, 8'h00, 6, 0, 32'h0F);
        add(8'h00, R, 3'd2, 8'h00, 0, 8'h00, 6, 0, 32'hFE);
        add(8'h00, R, 3'd5, 8'h00, 0, 8'h00, 6, 0, 32'h00);
        add(8'h00, R, 3'd3, 8'h00, 0, 8'h00, 6, 0, 32'h06);
        // 6: get line 2 into service before the reset sequence
        add(8'h04, N, 3'd0, 8'h00, 0, 8'h00, 6, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 6, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h00, 6, 0, 0);
        add(8'h00, N, 3'd0, 8'h00, 0, 8'h04, 2, 1, 0);
        add(8'h00, N, 3'd0, 8'h00, 1, 8'h00, 2, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            irq_in        = tbl[i].irq;
            reg_write     = tbl[i].op[0];
            reg_read      = tbl[i].op[1];
            reg_addr      = tbl[i].addr;
            reg_wdata     = {24'h0, tbl[i].wdata};
            interrupt_ack = tbl[i].ack;
            @(posedge clk);
            #1;
            if (tbl[i].op[1])
                chk($sformatf("step %0d", i),
                    {20'h0, interrupt_req, irq_vector, irq_active, reg_rdata},
                    {20'h0, tbl[i].exp_req, tbl[i].exp_vec, tbl[i].exp_act, tbl[i].exp_rd});
            else
                chk($sformatf("step %0d", i),
                    {52'h0, interrupt_req, irq_vector, irq_active},
                    {52'h0, tbl[i].exp_req, tbl[i].exp_vec, tbl[i].exp_act});
        end

        // Asynchronous reset while in service drops everything without a clock edge.
        @(negedge clk);
        reg_write = 1'b0; reg_read = 1'b0; interrupt_ack = 1'b0;
        reg_addr = RegStatusTb(); reg_read = 1'b1;
        @(posedge clk);
        #1;
        chk("status in service", reg_rdata, 64'h82);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset", {reg_rdata, interrupt_req, 5'(irq_vector), 8'(irq_active)}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1; reg_read = 1'b0; interrupt_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("ack ignored", {56'h0, interrupt_req}, {63'h0, irq_active});
        chk("ack idle", {63'h0, irq_active}, 64'h0);
        @(negedge clk);
        interrupt_ack = 1'b0; reg_read = 1'b1; reg_addr = 3'd0;
        @(posedge clk);
        #1;
        chk("enable after reset", {32'h0, reg_rdata}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    function automatic logic [2:0] RegStatusTb();
        return 3'd3;
    endfunction

endmodule
